// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared types, widths and frame layout for the SPI memory master
package spi_mem_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DONE} state_t;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DATA_W = 8;
  localparam int FRAME_BITS = DEF_ADDR_W + 1 + DEF_DATA_W;
  // MSB first: address, rw, then data (zeroed on reads)
  function automatic logic [FRAME_BITS-1:0] frame_word(input logic [DEF_ADDR_W-1:0] a, input logic r,
                                                       input logic [DEF_DATA_W-1:0] d);
    return {a, r, d & {DEF_DATA_W{~r}}};
  endfunction
endpackage

// File: rtl/spi_mem_master_sclk_gen.sv
// sclk_gen: H-cycle divider producing sclk and one-cycle rise/fall strobes
module sclk_gen #(
  parameter int H = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CW = $clog2(H + 1);
  logic [CW-1:0] cnt;
  logic tick;
  always_comb begin
    tick = en && cnt == CW'(H - 1);
    rise_stb = tick && !sclk;
    fall_stb = tick && sclk;
  end
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      sclk <= sclk ^ tick;
    end
  end
endmodule

// File: rtl/spi_mem_master.sv
// spi_mem_master: runs one 16-bit SPI read or write frame per accepted start
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);
  state_t state, state_nxt;
  logic [FRAME_BITS-1:0] tx;
  logic [DATA_W-1:0] rx;
  logic [4:0] bit_cnt;
  logic rw_q, sclk_q, rise_stb, fall_stb, load;
  sclk_gen #(.H(CLK_DIV)) u_sclk (
    .clk(clk),
    .reset(reset),
    .en(busy),
    .clr(!busy),
    .sclk(sclk_q),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb)
  );
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // HOLD ends on the divider's next rise tick, which is exactly H cycles after the last fall
  always_comb begin
    state_nxt = state == IDLE  ? (start ? SHIFT : IDLE)
              : state == SHIFT ? (fall_stb && bit_cnt == 5'(FRAME_BITS - 1) ? HOLD : SHIFT)
              : state == HOLD  ? (rise_stb ? DONE : HOLD)
              : IDLE;
  end
  always_comb begin
    busy = state == SHIFT || state == HOLD;
    cs = !busy;
    done = state == DONE;
    sclk = sclk_q && state == SHIFT;
    mosi = busy && tx[FRAME_BITS-1];
    load = state == IDLE && start;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= '0;
      rx <= '0;
      bit_cnt <= '0;
      rw_q <= 1'b0;
      rdata <= '0;
    end else begin
      if (load) begin
        tx <= frame_word(addr, rw, wdata);
        bit_cnt <= '0;
        rw_q <= rw;
      end else if (fall_stb) begin
        tx <= {tx[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (rise_stb && state == SHIFT && bit_cnt >= 5'(ADDR_W + 1)) rx <= {rx[DATA_W-2:0], miso};
      if (rise_stb && state == HOLD && rw_q) rdata <= rx;
    end
  end
endmodule

// File: tb/tb_spi_mem_master.sv
// tb_spi_mem_master: scoreboard bench for CLK_DIV=4 and CLK_DIV=1 instances with a MISO slave model
module tb_spi_mem_master;
  typedef struct {
    int done_at;
    logic [15:0] frame;
    logic [7:0] rdata;
  } exp_t;
  exp_t q0[$], q1[$], e;
  logic clk = 0;
  int cyc = 0, errors = 0, checks = 0, t0, t1;
  logic [1:0] reset, start, rw, busy, done, cs, sclk, mosi, miso;
  logic [1:0] psclk = 2'b00, pcs = 2'b11;
  logic [6:0] addr[2];
  logic [7:0] wdata[2], rdata[2], sdata[2];
  logic [15:0] frame[2];
  int fcnt[2];

  spi_mem_master #(.CLK_DIV(4)) u4 (
    .clk(clk), .reset(reset[0]), .start(start[0]), .rw(rw[0]), .addr(addr[0]), .wdata(wdata[0]),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]), .cs(cs[0]), .sclk(sclk[0]), .mosi(mosi[0]),
    .miso(miso[0])
  );
  spi_mem_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset[1]), .start(start[1]), .rw(rw[1]), .addr(addr[1]), .wdata(wdata[1]),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]), .cs(cs[1]), .sclk(sclk[1]), .mosi(mosi[1]),
    .miso(miso[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc + 1, act, req);
    end
  endtask

  task automatic push(input int i, input int at, input logic [15:0] f, input logic [7:0] r);
    exp_t x;
    x.done_at = at;
    x.frame = f;
    x.rdata = r;
    if (i == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic wait_to(input int lbl);
    while (cyc + 1 < lbl) @(negedge clk);
  endtask

  // request is scrambled after acceptance so the DUT must have latched it
  task automatic issue(input int i, input logic [6:0] a, input logic r, input logic [7:0] d,
                       input logic [7:0] sd, output int ts);
    @(negedge clk);
    addr[i] = a;
    rw[i] = r;
    wdata[i] = d;
    sdata[i] = sd;
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    ts = cyc;
    start[i] = 1'b0;
    addr[i] = ~a;
    rw[i] = ~r;
    wdata[i] = ~d;
  endtask

  // monitor + slave model: capture MOSI at SCLK rises, drive MISO data bits after falls
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!cs[i] && pcs[i]) begin
        frame[i] = '0;
        fcnt[i] = 0;
      end
      if (sclk[i] && !psclk[i]) frame[i] = {frame[i][14:0], mosi[i]};
      if (!sclk[i] && psclk[i]) begin
        fcnt[i]++;
        if (fcnt[i] >= 8 && fcnt[i] < 16) miso[i] = sdata[i][15-fcnt[i]];
      end
      if (done[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done u%0d at cycle %0d: got done=1 want none", i, cyc + 1);
        end else begin
          if (i == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk($sformatf("done_cycle_u%0d", i), cyc + 1, e.done_at);
          chk($sformatf("mosi_frame_u%0d", i), int'(frame[i]), int'(e.frame));
          chk($sformatf("rdata_u%0d", i), int'(rdata[i]), int'(e.rdata));
        end
      end
      psclk[i] = sclk[i];
      pcs[i] = cs[i];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 2'b11;
    start = 2'b00;
    rw = 2'b00;
    miso = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0;
      wdata[i] = '0;
      sdata[i] = '0;
      frame[i] = '0;
      fcnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_cs", cs[i], 1);
      chk("reset_sclk", sclk[i], 0);
      chk("reset_mosi", mosi[i], 0);
      chk("reset_busy", busy[i], 0);
      chk("reset_done", done[i], 0);
      chk("reset_rdata", rdata[i], 0);
    end
    reset = 2'b00;
    // write 0x2A to 0x15
    issue(0, 7'h15, 1'b0, 8'h2A, 8'h00, t0);
    push(0, t0 + 133, 16'h2A2A, 8'h00);
    wait_to(t0 + 1);
    chk("first_cs", cs[0], 0);
    chk("first_busy", busy[0], 1);
    chk("first_mosi", mosi[0], 0);
    wait_to(t0 + 4);
    chk("sclk_low_before_rise", sclk[0], 0);
    wait_to(t0 + 5);
    chk("sclk_first_rise", sclk[0], 1);
    wait_to(t0 + 133);
    chk("busy_at_done", busy[0], 0);
    wait_to(t0 + 134);
    // read 0x7F, slave returns 0xA5
    issue(0, 7'h7F, 1'b1, 8'hFF, 8'hA5, t0);
    push(0, t0 + 133, 16'hFF00, 8'hA5);
    wait_to(t0 + 134);
    // start held through the whole frame: one frame, next starts at t0+135
    @(negedge clk);
    addr[0] = 7'h03;
    rw[0] = 1'b1;
    sdata[0] = 8'h5A;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    push(0, t0 + 133, 16'h0700, 8'h5A);
    push(0, t0 + 267, 16'h0700, 8'h5A);
    wait_to(t0 + 134);
    chk("held_start_idle_cs", cs[0], 1);
    wait_to(t0 + 135);
    chk("held_start_second_cs", cs[0], 0);
    start[0] = 1'b0;
    wait_to(t0 + 268);
    // reset mid-write: no done, outputs back to reset values
    issue(0, 7'h55, 1'b0, 8'hC3, 8'h00, t0);
    wait_to(t0 + 40);
    reset[0] = 1'b1;
    wait_to(t0 + 41);
    chk("midreset_cs", cs[0], 1);
    chk("midreset_sclk", sclk[0], 0);
    chk("midreset_busy", busy[0], 0);
    chk("midreset_mosi", mosi[0], 0);
    chk("midreset_rdata", rdata[0], 0);
    reset[0] = 1'b0;
    wait_to(t0 + 180);
    // two reads: rdata holds 0x11 until the second done
    issue(0, 7'h11, 1'b1, 8'h00, 8'h11, t0);
    push(0, t0 + 133, 16'h2300, 8'h11);
    wait_to(t0 + 134);
    issue(0, 7'h22, 1'b1, 8'h00, 8'h22, t1);
    push(0, t1 + 133, 16'h4500, 8'h22);
    wait_to(t1 + 60);
    chk("rdata_hold_mid", rdata[0], 8'h11);
    wait_to(t1 + 132);
    chk("rdata_hold_pre_done", rdata[0], 8'h11);
    wait_to(t1 + 134);
    // CLK_DIV=1 read of 0x3C
    issue(1, 7'h3C, 1'b1, 8'h00, 8'h3C, t0);
    push(1, t0 + 34, 16'h7900, 8'h3C);
    wait_to(t0 + 2);
    chk("div1_sclk_rise", sclk[1], 1);
    wait_to(t0 + 3);
    chk("div1_sclk_fall", sclk[1], 0);
    wait_to(t0 + 40);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_mem_master.md
# spi_mem_master

System-clock-domain SPI master that runs single read or write frames against the SPI memory block, which contains the slave FSM, shift register, address latch and data memory. It converts a parallel request (address, direction, write data) into one 16-bit SPI frame (CS, SCLK, MOSI) and returns read data captured from MISO. It is the host-side sequencer for that memory and is also the stimulus driver for system-level benches.

## Interface
Parameters:
- CLK_DIV, 4, system clocks per SCLK half-period (H); legal range ≥1
- ADDR_W, 7, address bits per frame
- DATA_W, 8, data bits per frame

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request strobe; sampled only in IDLE
- rw  input  1  1 = read, 0 = write; sampled with start
- addr  input  ADDR_W  target address; sampled with start
- wdata  input  DATA_W  write data; sampled with start
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- rdata  output  DATA_W  last read result
- cs  output  1  chip select, active-low
- sclk  output  1  serial clock, idle low
- mosi  output  1  serial data to slave
- miso  input  1  serial data from slave

## Operation
- Frame, MSB first: addr[ADDR_W-1:0], then rw, then DATA_W data bits. Total FRAME_BITS = ADDR_W+1+DATA_W = 16.
- Data bits: a write drives wdata; a read drives 0 on MOSI and samples MISO.
- Master changes MOSI on SCLK falling edges. The first bit is valid when CS falls.
- Master samples MISO on SCLK rising edges, during data bits only. Sampled bits shift into an rx register.
- States:
  - IDLE: cs=1, sclk=0, busy=0. start → SHIFT; the request is latched.
  - SHIFT: cs=0. SCLK toggles every H cycles, starting low. A bit counter counts falling edges; the 16th falling edge → HOLD.
  - HOLD: sclk=0, cs=0 for H cycles → DONE.
  - DONE: cs=1, done=1, busy=0. On a read, rdata ← rx register; on a write, rdata is unchanged. Unconditional → IDLE.
- start is ignored in SHIFT, HOLD and DONE. It is not queued.
- rw, addr and wdata may change freely once start has been accepted.
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state=IDLE.
- Reset mid-frame: on the next edge, outputs return to reset values. The frame is abandoned and done does not pulse.

## Timing
Cycle numbering: start is sampled high in IDLE at edge t0.
- t0+1: cs=0, busy=1, mosi=addr MSB.
- Rising edge k of SCLK (k=1..16) at t0+1+(2k−1)H; falling edge k at t0+1+2kH.
- MOSI bit k+1 is valid from falling edge k.
- done=1 and cs=1 at t0+1+33H. busy is high for exactly 33H cycles (t0+1 … t0+33H).
- rdata is valid from the done cycle onward.
- With CLK_DIV=4, done is at t0+133. Earliest next accepted start is sampled at t0+134.

## Structure
- Package spi_mem_pkg holds:
  - state enum (IDLE, SHIFT, HOLD, DONE)
  - FRAME_BITS, ADDR_W and DATA_W defaults
  - the frame bit-order constant: address, then rw, then data.
- Sub-module sclk_gen:
  - H-cycle divider counter with enable, clear and sclk register
  - outputs one-cycle rise_stb and fall_stb
  - the top FSM consumes only these strobes.
- Top module: FSM, 16-bit tx shift register, DATA_W-bit rx shift register, 5-bit bit counter.

## Test plan
- Write: CLK_DIV=4, addr=0x15, rw=0, wdata=0x2A → MOSI at the 16 rising edges is 0010101_0_00101010; done at t0+133; rdata stays 0x00.
- Read: addr=0x7F, rw=1, slave model drives 0xA5 MSB-first on data-bit falling edges → MOSI 1111111_1_00000000; rdata=0xA5 at done.
- start held high through a whole frame, including the done cycle → exactly one frame; second frame begins with cs=0 at t0+135.
- reset asserted at t0+40 during a write → next cycle cs=1, sclk=0, busy=0; no done pulse; rdata=0.
- CLK_DIV=1, read of 0x3C → SCLK toggles every cycle; done at t0+34; rdata=0x3C.
- Two reads in sequence (0x11 then 0x22) → rdata updates only at each done pulse, holding 0x11 between them.
